// File: rtl/fetch_exec_ctrl_pkg.sv
// Shared core definitions for the fetch/execute sequencer: state encoding,
// reset PC and the latched execute-result payload.
package fetch_exec_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned WAIT_W    = 8;
    localparam int unsigned INSTRET_W = 64;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        WB         = 3'd3,
        HALT       = 3'd4,
        ERROR      = 3'd5
    } state_e;

    // Result of a completed execute, held until the write-back cycle.
    typedef struct packed {
        logic [XLEN-1:0] next_pc;
        logic            wb_req;
    } exec_res_t;

    // Sequential or redirected successor PC; the add wraps at 32 bits.
    function automatic logic [XLEN-1:0] calc_next_pc(
        input logic [XLEN-1:0] cur_pc,
        input logic            redirect,
        input logic [XLEN-1:0] target
    );
        return redirect ? target : cur_pc + XLEN'(4);
    endfunction

    // Instruction targets must be word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_exec_ctrl.sv
// Single-issue fetch/execute/write-back sequencer. Issues one instruction
// fetch at a time, waits (with timeout) for the response, hands the
// instruction to execute, and commits PC/instret in a one-cycle WB step.
module fetch_exec_ctrl
    import fetch_exec_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,

    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,

    output logic [31:0] inst,
    output logic        inst_valid,

    input  logic        exe_done,
    input  logic        exe_redirect,
    input  logic [31:0] exe_target,
    input  logic        exe_halt,
    input  logic        wb_req,

    output logic        r_wen,

    output logic [31:0] pc,
    output logic [63:0] instret,
    output logic        halted,
    output logic        error
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    state_e            state;
    state_e            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    exec_res_t         exec_res;
    exec_res_t         exec_res_d;

    logic req_valid_d;
    logic inst_valid_d;
    logic r_wen_d;
    logic halted_d;
    logic error_d;

    // The request address is the architectural PC itself, so it is
    // naturally stable while the handshake is stalled.
    assign imem_addr = pc;

    // Execute result candidate: successor PC and write-back request.
    always_comb begin
        exec_res_d.next_pc = calc_next_pc(pc, exe_redirect, exe_target);
        exec_res_d.wb_req  = wb_req;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a response beats a same-cycle timeout.
    always_comb begin
        state_next = state;
        case (state)
            FETCH_REQ: begin
                if (imem_req_ready) begin
                    state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    state_next = imem_resp_err ? ERROR : EXEC;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    state_next = ERROR;
                end
            end
            EXEC: begin
                if (exe_done) begin
                    if (exe_halt) begin
                        state_next = HALT;
                    end else if (exe_redirect && is_misaligned(exe_target)) begin
                        state_next = ERROR;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB:      state_next = FETCH_REQ;
            HALT:    state_next = HALT;
            ERROR:   state_next = ERROR;
            default: state_next = ERROR;
        endcase
    end

    // Output decode of the upcoming state, registered below.
    always_comb begin
        req_valid_d  = 1'b0;
        inst_valid_d = 1'b0;
        r_wen_d      = 1'b0;
        halted_d     = 1'b0;
        error_d      = 1'b0;
        case (state_next)
            FETCH_REQ: req_valid_d  = 1'b1;
            EXEC:      inst_valid_d = 1'b1;
            WB:        r_wen_d      = exec_res_d.wb_req;
            HALT:      halted_d     = 1'b1;
            ERROR:     error_d      = 1'b1;
            default:   ;
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_req_valid <= 1'b1;
            inst_valid     <= 1'b0;
            r_wen          <= 1'b0;
            halted         <= 1'b0;
            error          <= 1'b0;
        end else begin
            imem_req_valid <= req_valid_d;
            inst_valid     <= inst_valid_d;
            r_wen          <= r_wen_d;
            halted         <= halted_d;
            error          <= error_d;
        end
    end

    // Fetch wait counter: cleared on entry to FETCH_WAIT, counts while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != FETCH_WAIT && state_next == FETCH_WAIT) begin
            wait_cnt <= '0;
        end else if (state == FETCH_WAIT && state_next == FETCH_WAIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Instruction, execute result, PC and retired-instruction count.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst     <= '0;
            exec_res <= '0;
            pc       <= RESET_PC;
            instret  <= '0;
        end else begin
            if (state == FETCH_WAIT && state_next == EXEC) begin
                inst <= imem_resp_data;
            end
            if (state == EXEC && state_next == WB) begin
                exec_res <= exec_res_d;
            end
            if (state == WB) begin
                pc      <= exec_res.next_pc;
                instret <= instret + INSTRET_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Scoreboard bench for fetch_exec_ctrl: expected fetch addresses and
// write enables are queued when execute results are driven, then checked
// when the DUT issues the next request / enters write-back.
module tb_fetch_exec_ctrl;

    localparam logic [31:0] RST_PC  = 32'h8000_0000;
    localparam int unsigned TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exe_done;
    logic        exe_redirect;
    logic [31:0] exe_target;
    logic        exe_halt;
    logic        wb_req;
    logic        r_wen;
    logic [31:0] pc;
    logic [63:0] instret;
    logic        halted;
    logic        error;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] addr_q[$];
    logic        wen_q[$];
    logic [31:0] model_pc;
    logic [63:0] model_instret;

    fetch_exec_ctrl #(
        .RESET_PC    (RST_PC),
        .MEM_TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .exe_done        (exe_done),
        .exe_redirect    (exe_redirect),
        .exe_target      (exe_target),
        .exe_halt        (exe_halt),
        .wb_req          (wb_req),
        .r_wen           (r_wen),
        .pc              (pc),
        .instret         (instret),
        .halted          (halted),
        .error           (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        exe_done        = 1'b0;
        exe_redirect    = 1'b0;
        exe_target      = '0;
        exe_halt        = 1'b0;
        wb_req          = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        check("rst_pc", pc, RST_PC);
        check("rst_instret", instret, 64'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_flags", {halted, error, r_wen, inst_valid}, 4'b0000);
        check("rst_req_valid", imem_req_valid, 1'b1);
        rst = 1'b0;
        addr_q.delete();
        wen_q.delete();
        model_pc      = RST_PC;
        model_instret = '0;
        addr_q.push_back(RST_PC);
    endtask

    // Wait for the request, compare its address, stall, then accept it.
    task automatic fetch_accept(input int ready_delay);
        int          n = 0;
        logic [31:0] exp_addr = '0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        check("req_valid", imem_req_valid, 1'b1);
        if (addr_q.size() == 0) begin
            check("addr_q_underflow", 1'b1, 1'b0);
        end else begin
            exp_addr = addr_q.pop_front();
            check("imem_addr", imem_addr, exp_addr);
        end
        for (int i = 0; i < ready_delay; i++) begin
            step();
            check("bp_req_valid", imem_req_valid, 1'b1);
            check("bp_imem_addr", imem_addr, exp_addr);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("wait_req_low", imem_req_valid, 1'b0);
    endtask

    task automatic respond(input logic [31:0] data);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        step();
        imem_resp_valid = 1'b0;
        check("exec_inst_valid", inst_valid, 1'b1);
        check("exec_inst", inst, data);
        check("exec_error", error, 1'b0);
    endtask

    // Drive exe_done and check the resulting WB / HALT / ERROR behaviour.
    task automatic do_exec(input logic redir, input logic [31:0] tgt,
                           input logic halt, input logic wb);
        logic [31:0] nxt;
        exe_done     = 1'b1;
        exe_redirect = redir;
        exe_target   = tgt;
        exe_halt     = halt;
        wb_req       = wb;
        nxt = redir ? tgt : model_pc + 32'd4;
        if (halt) begin
            step();
            clear_inputs();
            for (int i = 0; i < 5; i++) begin
                check("halt_halted", halted, 1'b1);
                check("halt_req_valid", imem_req_valid, 1'b0);
                check("halt_instret", instret, model_instret);
                step();
            end
        end else if (redir && tgt[1:0] != 2'b00) begin
            step();
            clear_inputs();
            for (int i = 0; i < 3; i++) begin
                check("misalign_error", error, 1'b1);
                check("misalign_pc", pc, model_pc);
                check("misalign_req_valid", imem_req_valid, 1'b0);
                step();
            end
        end else begin
            addr_q.push_back(nxt);
            wen_q.push_back(wb);
            step();
            clear_inputs();
            check("wb_r_wen", r_wen, wen_q.pop_front());
            check("wb_inst_valid", inst_valid, 1'b0);
            model_pc = nxt;
            model_instret++;
            step();
            check("post_wb_r_wen", r_wen, 1'b0);
            check("post_wb_pc", pc, model_pc);
            check("post_wb_instret", instret, model_instret);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_pc      = RST_PC;
        model_instret = '0;

        // Sequential fetches with write-back, then one without.
        apply_reset();
        fetch_accept(0);
        respond(32'h0000_0013);
        do_exec(1'b0, 32'h0, 1'b0, 1'b1);
        fetch_accept(0);
        respond(32'h0010_0093);
        do_exec(1'b0, 32'h0, 1'b0, 1'b1);
        check("instret_two", instret, 64'd2);
        fetch_accept(0);
        respond(32'h1234_5678);
        do_exec(1'b1, 32'h8000_0100, 1'b0, 1'b0);

        // Backpressure on the redirected fetch, then misaligned redirect.
        fetch_accept(10);
        respond(32'hCAFE_0001);
        do_exec(1'b1, 32'h8000_0102, 1'b0, 1'b1);

        // Response on exactly the timeout cycle still wins.
        apply_reset();
        fetch_accept(0);
        repeat (TIMEOUT) step();
        respond(32'hA5A5_5A5A);
        do_exec(1'b0, 32'h0, 1'b0, 1'b1);

        // No response: error after the timeout cycle.
        fetch_accept(0);
        repeat (TIMEOUT) step();
        check("pre_timeout_error", error, 1'b0);
        step();
        check("timeout_error", error, 1'b1);
        check("timeout_req_valid", imem_req_valid, 1'b0);

        // Reset mid-fetch, then a stale response must be ignored.
        apply_reset();
        fetch_accept(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        check("stale_req_valid", imem_req_valid, 1'b1);
        check("stale_inst_valid", inst_valid, 1'b0);
        check("stale_inst", inst, 32'd0);
        check("stale_pc", pc, RST_PC);
        addr_q.delete();
        addr_q.push_back(RST_PC);
        fetch_accept(0);
        respond(32'h0000_0073);

        // Halt takes priority over a simultaneous redirect.
        do_exec(1'b1, 32'h8000_0200, 1'b1, 1'b1);

        // Error response from memory.
        apply_reset();
        fetch_accept(0);
        imem_resp_valid = 1'b1;
        imem_resp_err   = 1'b1;
        imem_resp_data  = 32'hFFFF_FFFF;
        step();
        clear_inputs();
        check("resp_err_error", error, 1'b1);
        check("resp_err_inst_valid", inst_valid, 1'b0);
        step();
        check("resp_err_absorbing", error, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
